// File: rtl/uart_tx_fsm_if.sv
// Handshake and mux-control bundle between the data source, the frame sequencer
// and the registered TX output mux.
interface uart_tx_fsm_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  par_en;
   logic                  par_typ;
   logic [2:0]            mux_sel;
   logic                  ser_data;
   logic                  par_bit;
   logic                  busy;

   modport master (
      output p_data, data_valid, par_en, par_typ,
      input  mux_sel, ser_data, par_bit, busy
   );

   modport slave (
      input  p_data, data_valid, par_en, par_typ,
      output mux_sel, ser_data, par_bit, busy
   );
endinterface

// File: rtl/uart_tx_fsm.sv
// UART TX frame sequencer: start / LSB-first data / optional parity / stop, one bit per clk.
// Define UART_TX_BACK2BACK_EN to let a request seen in STOP start the next frame with no idle gap.
module uart_tx_fsm #(
   parameter int DATA_WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   uart_tx_fsm_if.slave bus
);
   localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

   // State codes equal the mux select they drive, so decoding is a straight copy.
   typedef enum logic [2:0] {
      S_START  = 3'b000,
      S_IDLE   = 3'b001,
      S_DATA   = 3'b010,
      S_PARITY = 3'b011,
      S_STOP   = 3'b100
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  par_en_q, par_en_d;
   logic                  par_bit_q, par_bit_d;
   logic                  load;
   logic [2:0]            mux_sel;
   logic                  busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      load      = 1'b0;
      mux_sel   = 3'b001;
      busy      = 1'b0;

      case (state_q)
         S_IDLE: begin
            load = bus.data_valid;
         end
         S_START: begin
            mux_sel = 3'b000;
            busy    = 1'b1;
            cnt_d   = '0;
            state_d = S_DATA;
         end
         S_DATA: begin
            mux_sel = 3'b010;
            busy    = 1'b1;
            shift_d = shift_q >> 1;
            // Clear rather than increment on the last bit so the counter never wraps.
            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = par_en_q ? S_PARITY : S_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_PARITY: begin
            mux_sel = 3'b011;
            busy    = 1'b1;
            state_d = S_STOP;
         end
         S_STOP: begin
            mux_sel = 3'b100;
            busy    = 1'b1;
            state_d = S_IDLE;
`ifdef UART_TX_BACK2BACK_EN
            load    = bus.data_valid;
`endif
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // par_typ only matters at load time, so it is folded into par_bit here.
      if (load) begin
         shift_d   = bus.p_data;
         par_en_d  = bus.par_en;
         par_bit_d = bus.par_typ ? ~^bus.p_data : ^bus.p_data;
         cnt_d     = '0;
         state_d   = S_START;
      end
   end

   assign bus.mux_sel  = mux_sel;
   assign bus.busy     = busy;
   assign bus.ser_data = shift_q[0];
   assign bus.par_bit  = par_bit_q;
endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed + randomized bench for uart_tx_fsm against a per-frame sequence model.
module tb_uart_tx_fsm;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   fails = 0;

   uart_tx_fsm_if #(.DATA_WIDTH(W)) bus ();

   uart_tx_fsm #(.DATA_WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Parity bit so that the data ones plus the parity bit is even (pt=0) or odd (pt=1).
   function automatic logic exp_par(input logic [W-1:0] w, input logic pt);
      return logic'(($countones(w) % 2) == 1) ^ pt;
   endfunction

   task automatic start_frame(input logic [W-1:0] w, input logic pe, input logic pt);
      bus.p_data     = w;
      bus.par_en     = pe;
      bus.par_typ    = pt;
      bus.data_valid = 1'b1;
      step();
      bus.data_valid = 1'b0;
   endtask

   // Walks one frame starting at its START cycle; expected mux code per cycle is
   // start, W data slots, optional parity, stop.
   task automatic check_frame(input string tag, input logic [W-1:0] w, input logic pe,
                              input logic pt, input bit noise, input int dir_at,
                              input bit hold_dv);
      logic [2:0] seq[$];
      seq.push_back(3'd0);
      for (int k = 0; k < W; k++) seq.push_back(3'd2);
      if (pe) seq.push_back(3'd3);
      seq.push_back(3'd4);
      for (int i = 0; i < seq.size(); i++) begin
         chk($sformatf("%s mux[%0d]", tag, i), 32'(bus.mux_sel), 32'(seq[i]));
         chk($sformatf("%s busy[%0d]", tag, i), 32'(bus.busy), 32'd1);
         chk($sformatf("%s par[%0d]", tag, i), 32'(bus.par_bit), 32'(exp_par(w, pt)));
         if (seq[i] == 3'd2)
            chk($sformatf("%s ser[%0d]", tag, i), 32'(bus.ser_data), 32'(w[i-1]));
         if (!hold_dv) begin
            bus.data_valid = 1'b0;
            if (noise && seq[i] != 3'd4) begin
               bus.p_data     = W'($urandom);
               bus.par_en     = 1'($urandom);
               bus.par_typ    = 1'($urandom);
               bus.data_valid = 1'($urandom);
            end
            if (i == dir_at) begin
               bus.p_data     = '1;
               bus.data_valid = 1'b1;
            end
         end
         step();
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " mux"}, 32'(bus.mux_sel), 32'd1);
      chk({tag, " busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic [W-1:0] w;
      logic         pe, pt;

      // Reset with a pending request: nothing may start.
      rst            = 1'b1;
      bus.p_data     = 8'hA5;
      bus.par_en     = 1'b1;
      bus.par_typ    = 1'b1;
      bus.data_valid = 1'b1;
      step();
      step();
      chk_idle("reset");
      chk("reset par", 32'(bus.par_bit), 32'd0);
      chk("reset ser", 32'(bus.ser_data), 32'd0);
      rst            = 1'b0;
      bus.data_valid = 1'b0;
      step();
      chk_idle("post_reset");

      start_frame(8'hA5, 1'b1, 1'b0);
      check_frame("even_A5", 8'hA5, 1'b1, 1'b0, 1'b0, -1, 1'b0);
      chk_idle("even_A5 end");

      start_frame(8'h01, 1'b0, 1'b0);
      check_frame("nopar_01", 8'h01, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      chk_idle("nopar_01 end");

      start_frame(8'h07, 1'b1, 1'b1);
      check_frame("odd_07", 8'h07, 1'b1, 1'b1, 1'b0, -1, 1'b0);
      chk_idle("odd_07 end");

      start_frame(8'h07, 1'b1, 1'b0);
      check_frame("even_07", 8'h07, 1'b1, 1'b0, 1'b0, -1, 1'b0);
      chk_idle("even_07 end");

      // Request with p_data=FF while in DATA cycle 3 (sequence index 4).
      start_frame(8'h3C, 1'b1, 1'b0);
      check_frame("intf_3C", 8'h3C, 1'b1, 1'b0, 1'b0, 4, 1'b0);
      chk_idle("intf_3C end");

      // Reset arriving in DATA cycle 5 aborts the frame.
      start_frame(8'h3C, 1'b1, 1'b0);
      chk("abort start", 32'(bus.mux_sel), 32'd0);
      repeat (6) step();
      chk("abort data5 mux", 32'(bus.mux_sel), 32'd2);
      chk("abort data5 ser", 32'(bus.ser_data), 32'(1'b1));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle("abort");
      chk("abort par", 32'(bus.par_bit), 32'd0);
      step();
      chk_idle("abort hold");

      // Back-to-back with data_valid held through the first frame's STOP.
      bus.p_data     = 8'h5A;
      bus.par_en     = 1'b1;
      bus.par_typ    = 1'b0;
      bus.data_valid = 1'b1;
      step();
      bus.p_data = 8'hC3;
      check_frame("b2b_1", 8'h5A, 1'b1, 1'b0, 1'b0, -1, 1'b1);
`ifndef UART_TX_BACK2BACK_EN
      chk_idle("b2b gap");
      step();
`endif
      check_frame("b2b_2", 8'hC3, 1'b1, 1'b0, 1'b0, -1, 1'b0);
      chk_idle("b2b end");

      // Random frames with input noise while busy.
      for (int n = 0; n < 10; n++) begin
         w  = W'($urandom);
         pe = 1'($urandom);
         pt = 1'($urandom);
         start_frame(w, pe, pt);
         check_frame($sformatf("rnd%0d", n), w, pe, pt, 1'b1, -1, 1'b0);
         chk_idle($sformatf("rnd%0d end", n));
      end

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
- Frame sequencer for the UART transmitter; drives the select of the registered TX output mux.
- Latches a parallel word, serialises it LSB-first, computes parity and walks the start/data/parity/stop phases.
- Each phase lasts exactly one clock, so clk is the baud clock.
- Sits between the upstream data source (p_data/data_valid) and the output mux (mux_sel, ser_data, par_bit).

Parameters:
- DATA_WIDTH, 8, width of the parallel data word; must be >= 2.

Ports:
- clk       input   1             baud-rate clock; all state changes on posedge.
- rst       input   1             reset; synchronous, active-high.
- p_data    input   DATA_WIDTH    parallel word to transmit.
- data_valid input  1             request to send p_data; sampled only when a new frame may start.
- par_en    input   1             1 = frame includes a parity bit.
- par_typ   input   1             0 = even parity, 1 = odd parity.
- mux_sel   output  3             output-mux select: 000 start, 001 idle, 010 data, 011 parity, 100 stop.
- ser_data  output  1             current data bit for the mux (shift register LSB).
- par_bit   output  1             parity bit for the mux.
- busy      output  1             1 while a frame is in progress.

Behaviour:
- Reset (rst=1 at posedge): state IDLE, shift register 0, bit counter 0, latched par_en/par_typ 0, par_bit 0.
- Outputs after reset: mux_sel=001, busy=0, ser_data=0.
- Reset overrides everything. Mid-frame reset returns to IDLE on that edge and discards the frame.
- Outputs are Moore-decoded from the state register (mux_sel, busy). ser_data is shift_reg[0]. par_bit is a register.
- States:
  - IDLE: mux_sel=001, busy=0. If data_valid=1, latch p_data, par_en and par_typ. Load par_bit = ^p_data for even parity or ~^p_data for odd. Next state START.
  - START: 1 cycle, mux_sel=000, busy=1. Next state DATA, bit counter = 0.
  - DATA: DATA_WIDTH cycles, mux_sel=010. ser_data presents bit[counter]. Each edge shifts right by 1 and increments the counter. When counter = DATA_WIDTH-1, next state is PARITY if latched par_en=1, else STOP.
  - PARITY: 1 cycle, mux_sel=011. Next state STOP.
  - STOP: 1 cycle, mux_sel=100. Next state IDLE, except with the optional feature below.
- Frame length: DATA_WIDTH+3 cycles with parity, DATA_WIDTH+2 without.
- busy is high for exactly the frame length.
- Latency: data_valid sampled at edge n puts START in cycle n+1. Because the output mux is registered, the line shows the start bit one cycle later.
- data_valid, p_data, par_en and par_typ are ignored while busy=1. Latched values hold for the whole frame.
- The bit counter never wraps in DATA. Its width is clog2(DATA_WIDTH).
- No illegal state is reachable. Any undefined encoding goes to IDLE on the next edge.

Optional Feature:
- Macro UART_TX_BACK2BACK_EN.
- Defined: in STOP, if data_valid=1, latch the new word and parity exactly as in IDLE and go directly to START. busy stays 1 and there is no idle cycle between frames.
- Undefined: STOP always goes to IDLE, and data_valid during STOP is ignored. A held data_valid therefore produces one mux_sel=001 cycle between frames.

Test Plan:
- Reset: rst=1 for 2 cycles with data_valid=1 -> mux_sel=001, busy=0, par_bit=0. No frame starts until rst=0.
- Even parity: p_data=8'hA5, par_en=1, par_typ=0, data_valid pulsed 1 cycle.
  - mux_sel sequence: 000, 010 x8, 011, 100, 001.
  - ser_data during DATA: 1,0,1,0,0,1,0,1. par_bit=0. busy high for 11 cycles.
- No parity: p_data=8'h01, par_en=0 -> mux_sel 000, 010 x8, 100, then 001. busy high for 10 cycles and 011 never appears.
- Odd parity: p_data=8'h07, par_en=1, par_typ=1 -> par_bit=0. The same word with par_typ=0 -> par_bit=1.
- Interference: p_data=8'h3C frame. Pulse data_valid with p_data=8'hFF in DATA cycle 3 -> frame bits unchanged. A second run asserts rst in DATA cycle 5 -> IDLE, mux_sel=001, busy=0 on the next cycle.
- Back-to-back: data_valid held high, two frames.
  - Macro defined: STOP (100) is followed immediately by START (000).
  - Macro undefined: 100, 001, 000.
